fetch_stage: RTL and testbench

Instruction-fetch stage: owns the program counter, issues single-outstanding requests to instruction memory, and fills the IF/ID pipeline register. It sits directly downstream of the branch controller and consumes its `branch` / `branch_addr` outputs to redirect the PC and flush wrong-path instructions. It also honours the hazard unit's stall.

---
 rtl/fetch_stage_pkg.sv | 26 ++
 rtl/fetch_stage_if.sv | 26 ++
 rtl/fetch_stage_if_id_reg.sv | 33 +++
 rtl/fetch_stage.sv | 128 ++++++++++++
 tb/tb_fetch_stage.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared pipeline types for the fetch stage and the IF/ID boundary.
// The if_id_t struct is also consumed by the decode stage.
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    REQ,
    WAIT,
    HOLD,
    DROP
  } fetch_state_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
  } if_id_t;

  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and memory.
interface fetch_stage_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_valid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_valid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_valid,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register with flush, load and hold controls (flush wins).
// With neither load nor hold the held instruction is consumed and valid drops.
module fetch_stage_if_id_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   flush,
  input  logic   load,
  input  logic   hold,
  input  if_id_t load_data,
  output if_id_t q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.valid <= 1'b0;
      q.instr <= NOP_INSTR;
      q.pc    <= 32'h0;
      q.pc4   <= 32'h0;
    end else if (flush) begin
      q.valid <= 1'b0;
      q.instr <= NOP_INSTR;
    end else if (load) begin
      q <= load_data;
    end else if (!hold) begin
      q.valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, single-outstanding imem requests, skid buffer and IF/ID fill.
// All bus and IF/ID outputs come straight from registers.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 branch,
  input  logic [31:0]          branch_addr,
  input  logic                 stall,
  fetch_stage_if.master        imem,
  output logic                 if_id_valid,
  output logic [31:0]          if_id_instr,
  output logic [31:0]          if_id_pc,
  output logic [31:0]          if_id_pc4
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         req_q, req_d;
  logic [31:0]  skid_instr_q, skid_instr_d;
  logic [31:0]  skid_pc_q, skid_pc_d;
  logic         gnt_ok;
  logic         load;
  if_id_t       load_data;
  if_id_t       if_id_q;

  // req_q is low in the first cycle after reset, so a grant there is ignored
  assign gnt_ok = req_q & imem.imem_gnt;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    load         = 1'b0;
    load_data    = '0;

    unique case (state_q)
      REQ: begin
        if (gnt_ok) state_d = WAIT;
      end
      WAIT: begin
        if (imem.imem_valid) begin
          if (!stall || !if_id_q.valid) begin
            load      = 1'b1;
            load_data = '{valid: 1'b1, instr: imem.imem_rdata, pc: pc_q, pc4: pc_q + 32'd4};
            pc_d      = pc_q + 32'd4;
            state_d   = REQ;
          end else begin
            skid_instr_d = imem.imem_rdata;
            skid_pc_d    = pc_q;
            state_d      = HOLD;
          end
        end
      end
      HOLD: begin
        if (!stall) begin
          load      = 1'b1;
          load_data = '{valid: 1'b1, instr: skid_instr_q, pc: skid_pc_q,
                        pc4: skid_pc_q + 32'd4};
          pc_d      = pc_q + 32'd4;
          state_d   = REQ;
        end
      end
      DROP: begin
        if (imem.imem_valid) state_d = REQ;
      end
      default: state_d = REQ;
    endcase

    // Redirect overrides everything; only the outstanding-request bookkeeping survives
    if (branch) begin
      load         = 1'b0;
      pc_d         = word_align(branch_addr);
      skid_instr_d = 32'h0;
      skid_pc_d    = 32'h0;
      unique case (state_q)
        REQ:     state_d = gnt_ok ? DROP : REQ;
        WAIT:    state_d = imem.imem_valid ? REQ : DROP;
        HOLD:    state_d = REQ;
        DROP:    state_d = imem.imem_valid ? REQ : DROP;
        default: state_d = REQ;
      endcase
    end

    req_d = (state_d == REQ);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= REQ;
      pc_q         <= RESET_PC;
      req_q        <= 1'b0;
      skid_instr_q <= 32'h0;
      skid_pc_q    <= 32'h0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_q        <= req_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

  fetch_stage_if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (branch),
    .load      (load),
    .hold      (stall),
    .load_data (load_data),
    .q         (if_id_q)
  );

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc_q;
  assign if_id_valid    = if_id_q.valid;
  assign if_id_instr    = if_id_q.instr;
  assign if_id_pc       = if_id_q.pc;
  assign if_id_pc4      = if_id_q.pc4;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a small single-outstanding memory model.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        branch;
  logic [31:0] branch_addr;
  logic        stall;
  logic        if_id_valid;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc4;

  logic        gnt_en;
  logic        valid_en;
  logic        pend;
  logic [31:0] paddr;

  int n_assert = 0;
  int n_fail   = 0;

  fetch_stage_if bus ();

  fetch_stage #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (NOP)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .branch      (branch),
    .branch_addr (branch_addr),
    .stall       (stall),
    .imem        (bus),
    .if_id_valid (if_id_valid),
    .if_id_instr (if_id_instr),
    .if_id_pc    (if_id_pc),
    .if_id_pc4   (if_id_pc4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: grant when enabled, answer with addr + 32'h2001_0005 once valid_en allows
  assign bus.imem_gnt   = bus.imem_req & gnt_en;
  assign bus.imem_valid = pend & valid_en;
  assign bus.imem_rdata = paddr + 32'h2001_0005;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend  <= 1'b0;
      paddr <= 32'h0;
    end else begin
      if (bus.imem_valid) pend <= 1'b0;
      if (bus.imem_req && bus.imem_gnt) begin
        pend  <= 1'b1;
        paddr <= bus.imem_addr;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n       = 1'b0;
    branch      = 1'b0;
    branch_addr = 32'h0;
    stall       = 1'b0;
    gnt_en      = 1'b1;
    valid_en    = 1'b1;
    tick();
    tick();
    chk("rst_req", {31'b0, bus.imem_req}, 32'd0);
    chk("rst_valid", {31'b0, if_id_valid}, 32'd0);
    chk("rst_instr", if_id_instr, NOP);
    chk("rst_pc", if_id_pc, 32'h0);
    chk("rst_pc4", if_id_pc4, 32'h0);
    rst_n = 1'b1;

    // Cycle 1: first request
    tick();
    chk("c1_req", {31'b0, bus.imem_req}, 32'd1);
    chk("c1_addr", bus.imem_addr, 32'h0);
    tick();
    chk("c2_req_low", {31'b0, bus.imem_req}, 32'd0);
    tick();
    chk("c3_valid", {31'b0, if_id_valid}, 32'd1);
    chk("c3_instr", if_id_instr, 32'h2001_0005);
    chk("c3_pc", if_id_pc, 32'h0);
    chk("c3_pc4", if_id_pc4, 32'h4);
    chk("c3_addr", bus.imem_addr, 32'h4);

    // Stall for cycles 3..6 while the response for 0x4 arrives
    stall = 1'b1;
    tick();
    tick();
    chk("c5_state_hold", {30'b0, dut.state_q}, {30'b0, HOLD});
    chk("c5_hold_instr", if_id_instr, 32'h2001_0005);
    chk("c5_hold_pc", if_id_pc, 32'h0);
    chk("c5_hold_valid", {31'b0, if_id_valid}, 32'd1);
    chk("c5_req_low", {31'b0, bus.imem_req}, 32'd0);
    tick();
    chk("c6_hold_instr", if_id_instr, 32'h2001_0005);
    tick();
    stall = 1'b0;
    tick();
    chk("c8_skid_valid", {31'b0, if_id_valid}, 32'd1);
    chk("c8_skid_instr", if_id_instr, 32'h2001_0009);
    chk("c8_skid_pc", if_id_pc, 32'h4);
    chk("c8_skid_pc4", if_id_pc4, 32'h8);
    chk("c8_addr", bus.imem_addr, 32'h8);
    tick();
    tick();
    chk("c10_pc", if_id_pc, 32'h8);
    chk("c10_instr", if_id_instr, 32'h2001_000D);
    chk("c10_addr", bus.imem_addr, 32'hC);

    // Branch to 0x40 during WAIT with the response held back
    tick();
    valid_en    = 1'b0;
    branch      = 1'b1;
    branch_addr = 32'h0000_0040;
    tick();
    chk("c12_flush_valid", {31'b0, if_id_valid}, 32'd0);
    chk("c12_flush_instr", if_id_instr, NOP);
    chk("c12_state_drop", {30'b0, dut.state_q}, {30'b0, DROP});
    chk("c12_req_low", {31'b0, bus.imem_req}, 32'd0);
    branch   = 1'b0;
    valid_en = 1'b1;
    tick();
    chk("c13_addr", bus.imem_addr, 32'h40);
    chk("c13_req", {31'b0, bus.imem_req}, 32'd1);
    chk("c13_discarded", {31'b0, if_id_valid}, 32'd0);
    tick();
    tick();
    chk("c15_valid", {31'b0, if_id_valid}, 32'd1);
    chk("c15_pc", if_id_pc, 32'h40);
    chk("c15_instr", if_id_instr, 32'h2001_0045);

    // Branch and stall together; no grant this cycle
    stall       = 1'b1;
    branch      = 1'b1;
    branch_addr = 32'h0000_0200;
    gnt_en      = 1'b0;
    tick();
    chk("c16_bs_valid", {31'b0, if_id_valid}, 32'd0);
    chk("c16_bs_instr", if_id_instr, NOP);
    chk("c16_bs_addr", bus.imem_addr, 32'h200);
    chk("c16_bs_req", {31'b0, bus.imem_req}, 32'd1);
    stall  = 1'b0;
    branch = 1'b0;
    gnt_en = 1'b1;

    // Two back-to-back branches: 0x80 from WAIT, then 0x100 while in DROP
    tick();
    valid_en    = 1'b0;
    branch      = 1'b1;
    branch_addr = 32'h0000_0080;
    tick();
    branch_addr = 32'h0000_0100;
    tick();
    chk("c19_state_drop", {30'b0, dut.state_q}, {30'b0, DROP});
    chk("c19_req_low", {31'b0, bus.imem_req}, 32'd0);
    branch   = 1'b0;
    valid_en = 1'b1;
    tick();
    chk("c20_addr", bus.imem_addr, 32'h100);
    chk("c20_req", {31'b0, bus.imem_req}, 32'd1);
    tick();
    tick();
    chk("c22_valid", {31'b0, if_id_valid}, 32'd1);
    chk("c22_pc", if_id_pc, 32'h100);
    chk("c22_instr", if_id_instr, 32'h2001_0105);
    chk("c22_addr", bus.imem_addr, 32'h104);

    // PC wrap from 0xFFFF_FFFC
    branch      = 1'b1;
    branch_addr = 32'hFFFF_FFFC;
    gnt_en      = 1'b0;
    tick();
    chk("c23_addr", bus.imem_addr, 32'hFFFF_FFFC);
    branch = 1'b0;
    gnt_en = 1'b1;
    tick();
    tick();
    chk("c25_pc", if_id_pc, 32'hFFFF_FFFC);
    chk("c25_pc4_wrap", if_id_pc4, 32'h0);
    chk("c25_instr", if_id_instr, 32'h2001_0001);
    chk("c25_addr_wrap", bus.imem_addr, 32'h0);

    // Misaligned branch target is forced to a word boundary
    branch      = 1'b1;
    branch_addr = 32'h0000_0043;
    gnt_en      = 1'b0;
    tick();
    chk("c26_align", bus.imem_addr, 32'h40);
    branch = 1'b0;
    gnt_en = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
